adc_capture_ctrl: RTL and testbench

- Sits between the ADC deserializer and the ADC-to-USB clock-crossing FIFO, in the deserializer's divided-clock domain.
- Gates deserialized 64-bit ADC words into the FIFO for an armed, fixed-length capture.
- Drops words rather than overrunning when the FIFO reports no space, and counts the drops.
- Replaces the free-running "write whenever not full" path with a controlled record.

---
 rtl/dso_pkg.sv | 20 ++
 rtl/adc_ramp_gen.sv | 33 +++
 rtl/adc_capture_ctrl.sv | 162 ++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dso_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dso_pkg : shared ADC capture types and widths                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dso_pkg;

  localparam int ADC_DATA_W = 64;
  localparam int ADC_LANES  = 8;
  localparam int CAP_LEN_W  = 24;
  localparam int CAP_DROP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/adc_ramp_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_ramp_gen : 8-bit ramp replicated across all byte lanes           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adc_ramp_gen
  import dso_pkg::*;
#(
  parameter int LANES = ADC_LANES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_step,
  output logic [LANES*8-1:0] o_data
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (i_clear) begin
      r_cnt <= 8'd0;
    end else if (i_step) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_data = {LANES{r_cnt}};

endmodule
`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_capture_ctrl : armed fixed-length ADC record into the CDC FIFO,  |
// | dropping and counting words on almost-full. ADC_CAPTURE_TESTPAT_EN   |
// | adds i_test_mode and a lane-ramp source. Rev 1.0                     |
// +----------------------------------------------------------------------+
module adc_capture_ctrl
  import dso_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int LEN_W  = CAP_LEN_W,
  parameter int DROP_W = CAP_DROP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_arm,
  input  logic              i_abort,
  input  logic [LEN_W-1:0]  i_capture_len,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_din_valid,
  input  logic              i_fifo_afull,
`ifdef ADC_CAPTURE_TESTPAT_EN
  input  logic [3:0]        i_test_mode,
`endif
  output logic [DATA_W-1:0] o_fifo_din,
  output logic              o_fifo_wr_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic [DROP_W-1:0] o_drop_count
);

  cap_state_t r_state;
  cap_state_t w_state_nxt;

  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_slot_cnt;
  logic [DATA_W-1:0] r_fifo_din;
  logic              r_wr_en;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_busy;
  logic              w_done;
  logic              w_arm_ok;
  logic              w_slot;
  logic              w_write;
  logic              w_drop;
  logic [DATA_W-1:0] w_word;

`ifdef ADC_CAPTURE_TESTPAT_EN
  logic [DATA_W-1:0] w_ramp;
  logic              w_unused_test_mode;

  adc_ramp_gen #(
    .LANES (DATA_W / 8)
  ) u_ramp (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_arm_ok),
    .i_step  (w_slot),
    .o_data  (w_ramp)
  );

  assign w_word             = i_test_mode[0] ? w_ramp : i_din;
  assign w_unused_test_mode = ^i_test_mode[3:1];
`else
  assign w_word = i_din;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort outranks both arm and slot consumption in every state.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_arm_ok    = 1'b0;
    w_slot      = 1'b0;
    w_write     = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_abort && i_arm) begin
          if (i_capture_len != '0) begin
            w_arm_ok    = 1'b1;
            w_state_nxt = ST_CAPTURE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_CAPTURE: begin
        w_busy = 1'b1;
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (i_din_valid) begin
          w_slot  = 1'b1;
          w_write = !i_fifo_afull;
          w_drop  = i_fifo_afull;
          if (r_slot_cnt == r_len - LEN_W'(1)) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_slot_cnt <= '0;
      r_fifo_din <= '0;
      r_wr_en    <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_wr_en <= w_write;
      if (w_write) begin
        r_fifo_din <= w_word;
      end
      if (w_arm_ok) begin
        r_len      <= i_capture_len;
        r_slot_cnt <= '0;
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end else begin
        if (w_slot) begin
          r_slot_cnt <= r_slot_cnt + LEN_W'(1);
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
          if (r_drop_cnt != '1) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
          end
        end
      end
    end
  end

  assign o_fifo_din   = r_fifo_din;
  assign o_fifo_wr_en = r_wr_en;
  assign o_busy       = w_busy;
  assign o_done       = w_done;
  assign o_overflow   = r_overflow;
  assign o_drop_count = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adc_capture_ctrl : directed self-checking bench for the capture   |
// | controller. Rev 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_adc_capture_ctrl;

  localparam int DATA_W = 64;
  localparam int LEN_W  = 24;
  localparam int DROP_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              arm;
  logic              abort;
  logic [LEN_W-1:0]  capture_len;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              fifo_afull;
  logic [3:0]        test_mode;
  logic [DATA_W-1:0] fifo_din;
  logic              fifo_wr_en;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  adc_capture_ctrl #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .DROP_W (DROP_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_arm         (arm),
    .i_abort       (abort),
    .i_capture_len (capture_len),
    .i_din         (din),
    .i_din_valid   (din_valid),
    .i_fifo_afull  (fifo_afull),
`ifdef ADC_CAPTURE_TESTPAT_EN
    .i_test_mode   (test_mode),
`endif
    .o_fifo_din    (fifo_din),
    .o_fifo_wr_en  (fifo_wr_en),
    .o_busy        (busy),
    .o_done        (done),
    .o_overflow    (overflow),
    .o_drop_count  (drop_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one record cycle-by-cycle; per-cycle controls come from bit masks.
  task automatic run_capture(input logic do_arm, input logic [LEN_W-1:0] len,
                             input int ncyc, input logic [31:0] valid_m,
                             input logic [31:0] afull_m, input logic [31:0] arm_m,
                             input logic [31:0] abort_m,
                             output int writes, output int busy_cnt,
                             output int done_cnt, output int done_idx,
                             output int data_err);
    logic [DATA_W-1:0] exp;
    writes = 0; busy_cnt = 0; done_cnt = 0; done_idx = -2; data_err = 0;
    capture_len = len;
    if (do_arm) begin
      arm = 1'b1; din_valid = 1'b0; fifo_afull = 1'b0;
      tick;
      arm = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_idx = -1; end
      if (fifo_wr_en) writes++;
    end
    for (int i = 0; i < ncyc; i++) begin
      din        = {32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i)};
      din_valid  = valid_m[i];
      fifo_afull = afull_m[i];
      arm        = arm_m[i];
      abort      = abort_m[i];
      tick;
      if (fifo_wr_en) begin
        exp = test_mode[0] ? {8{writes[7:0]}} : din;
        if (fifo_din !== exp) data_err++;
        writes++;
      end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_idx = i; end
    end
    arm = 1'b0; abort = 1'b0; din_valid = 1'b0; fifo_afull = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tests_run++; if (fifo_wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en); end
    tests_run++; if (fifo_din !== '0) begin tests_failed++; $display("FAIL reset_fifo_din: got %h expected 0", fifo_din); end
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    tests_run++; if (overflow !== 1'b0 || drop_count !== '0) begin tests_failed++; $display("FAIL reset_overflow_drop: got %b/%0d expected 0/0", overflow, drop_count); end
  endtask

  task automatic test_basic;
    int w, b, d, di, e;
    run_capture(1'b1, 24'd16, 20, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, w, b, d, di, e);
    tests_run++; if (w !== 16) begin tests_failed++; $display("FAIL basic_writes: got %0d expected 16", w); end
    tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL basic_data: got %0d bad words expected 0", e); end
    tests_run++; if (b !== 16) begin tests_failed++; $display("FAIL basic_busy_cycles: got %0d expected 16", b); end
    tests_run++; if (d !== 1 || di !== 15) begin tests_failed++; $display("FAIL basic_done: got %0d pulses at %0d expected 1 at 15", d, di); end
    tests_run++; if (overflow !== 1'b0 || drop_count !== 4'd0) begin tests_failed++; $display("FAIL basic_no_drop: got %b/%0d expected 0/0", overflow, drop_count); end
  endtask

  task automatic test_backpressure;
    int w, b, d, di, e;
    run_capture(1'b1, 24'd10, 14, 32'hFFFF_FFFF, 32'h0000_001C, 32'h0, 32'h0, w, b, d, di, e);
    tests_run++; if (w !== 7) begin tests_failed++; $display("FAIL bp_writes: got %0d expected 7", w); end
    tests_run++; if (drop_count !== 4'd3) begin tests_failed++; $display("FAIL bp_drop_count: got %0d expected 3", drop_count); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
    tests_run++; if (d !== 1 || di !== 9) begin tests_failed++; $display("FAIL bp_done: got %0d pulses at %0d expected 1 at 9", d, di); end
  endtask

  task automatic test_gaps;
    int w, b, d, di, e;
    run_capture(1'b1, 24'd4, 10, 32'h5555_5555, 32'h0, 32'h0, 32'h0, w, b, d, di, e);
    tests_run++; if (w !== 4 || e !== 0) begin tests_failed++; $display("FAIL gaps_writes: got %0d writes %0d bad expected 4/0", w, e); end
    tests_run++; if (b !== 7) begin tests_failed++; $display("FAIL gaps_busy_cycles: got %0d expected 7", b); end
    tests_run++; if (d !== 1 || di !== 6) begin tests_failed++; $display("FAIL gaps_done: got %0d pulses at %0d expected 1 at 6", d, di); end
  endtask

  task automatic test_zero_and_rearm;
    int w, b, d, di, e;
    run_capture(1'b1, 24'd0, 4, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, w, b, d, di, e);
    tests_run++; if (w !== 0 || b !== 0) begin tests_failed++; $display("FAIL zero_len_activity: got %0d writes %0d busy expected 0/0", w, b); end
    tests_run++; if (d !== 1 || di !== -1) begin tests_failed++; $display("FAIL zero_len_done: got %0d pulses at %0d expected 1 at -1", d, di); end
    run_capture(1'b1, 24'd8, 12, 32'hFFFF_FFFF, 32'h0, 32'h0000_0018, 32'h0, w, b, d, di, e);
    tests_run++; if (w !== 8 || e !== 0) begin tests_failed++; $display("FAIL rearm_writes: got %0d writes %0d bad expected 8/0", w, e); end
    tests_run++; if (d !== 1 || di !== 7) begin tests_failed++; $display("FAIL rearm_done: got %0d pulses at %0d expected 1 at 7", d, di); end
  endtask

  task automatic test_saturation;
    int w, b, d, di, e;
    run_capture(1'b1, 24'd20, 24, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, w, b, d, di, e);
    tests_run++; if (drop_count !== 4'd15) begin tests_failed++; $display("FAIL sat_drop_count: got %0d expected 15", drop_count); end
    tests_run++; if (w !== 0 || overflow !== 1'b1) begin tests_failed++; $display("FAIL sat_writes_overflow: got %0d/%b expected 0/1", w, overflow); end
    tests_run++; if (d !== 1 || di !== 19) begin tests_failed++; $display("FAIL sat_done: got %0d pulses at %0d expected 1 at 19", d, di); end
  endtask

  task automatic test_abort;
    int w, b, d, di, e;
    run_capture(1'b1, 24'd20, 10, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0020, w, b, d, di, e);
    tests_run++; if (w !== 5 || e !== 0) begin tests_failed++; $display("FAIL abort_writes: got %0d writes %0d bad expected 5/0", w, e); end
    tests_run++; if (d !== 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d expected 0", d); end
    tests_run++; if (b !== 6 || busy !== 1'b0) begin tests_failed++; $display("FAIL abort_idle: got %0d busy cycles busy=%b expected 6/0", b, busy); end
    tests_run++; if (overflow !== 1'b0 || drop_count !== 4'd0) begin tests_failed++; $display("FAIL abort_cleared_by_arm: got %b/%0d expected 0/0", overflow, drop_count); end
  endtask

  task automatic test_reset_mid;
    int w, b, d, di, e;
    run_capture(1'b1, 24'd20, 5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0, w, b, d, di, e);
    rst = 1'b1; din_valid = 1'b1;
    tick;
    rst = 1'b0; din_valid = 1'b0;
    tests_run++; if (fifo_wr_en !== 1'b0 || fifo_din !== '0) begin tests_failed++; $display("FAIL rstmid_fifo: got %b/%h expected 0/0", fifo_wr_en, fifo_din); end
    tests_run++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || drop_count !== 4'd0) begin
      tests_failed++; $display("FAIL rstmid_status: got %b%b%b/%0d expected 000/0", busy, done, overflow, drop_count);
    end
    run_capture(1'b1, 24'd3, 6, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, w, b, d, di, e);
    tests_run++; if (w !== 3 || e !== 0 || d !== 1 || di !== 2) begin
      tests_failed++; $display("FAIL rstmid_rearm: got %0d writes %0d bad done %0d at %0d expected 3/0/1/2", w, e, d, di);
    end
  endtask

`ifdef ADC_CAPTURE_TESTPAT_EN
  task automatic test_testpat;
    int w, b, d, di, e;
    test_mode = 4'b0001;
    run_capture(1'b1, 24'd8, 10, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, w, b, d, di, e);
    test_mode = 4'b0000;
    tests_run++; if (w !== 8 || e !== 0) begin tests_failed++; $display("FAIL testpat_ramp: got %0d writes %0d bad expected 8/0", w, e); end
    tests_run++; if (fifo_din !== 64'h0707_0707_0707_0707) begin tests_failed++; $display("FAIL testpat_last: got %h expected 0707070707070707", fifo_din); end
  endtask
`endif

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; capture_len = '0; din = '0;
    din_valid = 1'b0; fifo_afull = 1'b0; test_mode = 4'b0000;
    test_reset;
    test_basic;
    test_backpressure;
    test_gaps;
    test_zero_and_rearm;
    test_saturation;
    test_abort;
    test_reset_mid;
`ifdef ADC_CAPTURE_TESTPAT_EN
    test_testpat;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
